// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared FSM state codes and default sizes for the stall controller
package pipeline_stall_ctrl_pkg;
   typedef logic [1:0] state_t;
   localparam state_t RUN      = 2'd0;
   localparam state_t MDU_WAIT = 2'd1;
   localparam state_t MDU_ERR  = 2'd2;
   localparam int DEF_CNT_W       = 32;
   localparam int DEF_MDU_MAX_CYC = 40;
endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard/MDU/branch inputs in, pipeline enables/bubbles and perf counters out
interface pipeline_stall_ctrl_if import pipeline_stall_ctrl_pkg::*; #(
   parameter int CNT_W = DEF_CNT_W
) ();
   logic             bb_data, mdu_start, mdu_done, branch_ex, cnt_clr;
   logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, mdu_err;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   modport master (
      output bb_data, mdu_start, mdu_done, branch_ex, cnt_clr,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, mdu_err,
             stall_cycles, flush_count
   );
   modport slave (
      input  bb_data, mdu_start, mdu_done, branch_ex, cnt_clr,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, mdu_err,
             stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: clk, rst_n, inc_i, clr_i (wins over inc) -> cnt_o, holds at all-ones
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: clk, rst_n, bus (slave) -> IF/ID/EX/MEM enables, flushes, bubbles, MDU watchdog, perf counters
module pipeline_stall_ctrl import pipeline_stall_ctrl_pkg::*; #(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int MDU_MAX_CYC = DEF_MDU_MAX_CYC,
   parameter int WD_W        = 6
) (
   input logic                  clk,
   input logic                  rst_n,
   pipeline_stall_ctrl_if.slave bus
);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(MDU_MAX_CYC);
   state_t          state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            busy, hold_id;
   always_comb begin
      busy    = (state_q == RUN && bus.mdu_start && !bus.mdu_done) ||
                (state_q == MDU_WAIT && !bus.mdu_done) || (state_q == MDU_ERR);
      // a taken branch squashes the ID instruction, so its hazard no longer matters
      hold_id = busy || (bus.bb_data && !bus.branch_ex);
      state_d = state_q;
      wd_d    = wd_q;
      if (state_q == RUN && bus.mdu_start && !bus.mdu_done) begin
         state_d = MDU_WAIT;
         wd_d    = WD_W'(1);
      end else if (state_q == MDU_WAIT) begin
         if (bus.mdu_done) begin
            state_d = RUN;
            wd_d    = '0;
         end else if (wd_q == WD_MAX) state_d = MDU_ERR;
         else wd_d = wd_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= RUN;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
      end
   assign bus.pc_en        = !hold_id;
   assign bus.ifid_en      = !hold_id;
   assign bus.idex_en      = !busy;
   assign bus.ifid_flush   = !busy && bus.branch_ex;
   assign bus.idex_bubble  = !busy && (bus.branch_ex || bus.bb_data);
   assign bus.exmem_bubble = busy;
   assign bus.mdu_err      = state_q == MDU_ERR;
   sat_counter #(.W(CNT_W)) u_stall (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (hold_id),
      .clr_i (bus.cnt_clr),
      .cnt_o (bus.stall_cycles)
   );
   sat_counter #(.W(CNT_W)) u_flush (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (!busy && bus.branch_ex),
      .clr_i (bus.cnt_clr),
      .cnt_o (bus.flush_count)
   );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: two parameterisations driven in lockstep and checked against a behavioural model
module tb_pipeline_stall_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   pipeline_stall_ctrl_if #(.CNT_W(32)) ifa ();
   pipeline_stall_ctrl_if #(.CNT_W(3))  ifb ();
   pipeline_stall_ctrl #(.CNT_W(32), .MDU_MAX_CYC(40), .WD_W(6)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   pipeline_stall_ctrl #(.CNT_W(3),  .MDU_MAX_CYC(4),  .WD_W(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   int     n_cmp = 0;
   int     n_mis = 0;
   int     max_cyc [2] = '{40, 4};
   longint cnt_max [2] = '{64'hFFFF_FFFF, 64'd7};
   int     m_wait  [2];
   bit     m_err   [2];
   longint m_stall [2];
   longint m_flush [2];
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [6:0] model_out(input int k, input bit b, s, d, br);
      bit busy = m_err[k] || (m_wait[k] != 0 && !d) || (m_wait[k] == 0 && s && !d);
      bit pc   = !busy && (br || !b);
      return {pc, pc, !busy && br, !busy, !busy && (br || b), busy, m_err[k]};
   endfunction
   task automatic step(input bit r, b, s, d, br, c);
      logic [6:0]  got_o [2];
      logic [63:0] got_s [2], got_f [2];
      logic [6:0]  e;
      @(negedge clk);
      rst_n = r;
      ifa.bb_data = b; ifa.mdu_start = s; ifa.mdu_done = d; ifa.branch_ex = br; ifa.cnt_clr = c;
      ifb.bb_data = b; ifb.mdu_start = s; ifb.mdu_done = d; ifb.branch_ex = br; ifb.cnt_clr = c;
      if (!r) for (int k = 0; k < 2; k++) begin
         m_wait[k] = 0; m_err[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end
      #1;
      got_o[0] = {ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idex_en, ifa.idex_bubble, ifa.exmem_bubble, ifa.mdu_err};
      got_o[1] = {ifb.pc_en, ifb.ifid_en, ifb.ifid_flush, ifb.idex_en, ifb.idex_bubble, ifb.exmem_bubble, ifb.mdu_err};
      got_s[0] = 64'(ifa.stall_cycles); got_f[0] = 64'(ifa.flush_count);
      got_s[1] = 64'(ifb.stall_cycles); got_f[1] = 64'(ifb.flush_count);
      for (int k = 0; k < 2; k++) begin
         e = model_out(k, b, s, d, br);
         check($sformatf("outs%0d", k), 64'(got_o[k]), 64'(e));
         check($sformatf("stall%0d", k), got_s[k], m_stall[k]);
         check($sformatf("flush%0d", k), got_f[k], m_flush[k]);
         if (r) begin
            m_stall[k] = c ? 0 : (!e[6] && m_stall[k] < cnt_max[k]) ? m_stall[k] + 1 : m_stall[k];
            m_flush[k] = c ? 0 : (e[4] && m_flush[k] < cnt_max[k]) ? m_flush[k] + 1 : m_flush[k];
            if (!m_err[k]) begin
               if (m_wait[k] != 0) begin
                  if (d) m_wait[k] = 0;
                  else if (m_wait[k] == max_cyc[k]) m_err[k] = 1;
                  else m_wait[k]++;
               end else if (s && !d) m_wait[k] = 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
   endtask
   initial begin
      step(0, 0, 0, 0, 0, 0);
      idle(1);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      check("bb_stall2", 64'(ifa.stall_cycles), 64'd2);
      check("bb_flush0", 64'(ifa.flush_count), 64'd0);
      step(1, 1, 0, 0, 1, 0);
      check("br_flush1", 64'(ifa.flush_count), 64'd1);
      step(1, 0, 1, 0, 0, 0);
      idle(4);
      step(1, 0, 0, 1, 0, 0);
      check("mdu5_stall", 64'(ifa.stall_cycles), 64'd7);
      check("mdu5_err_b", 64'(ifb.mdu_err), 64'd1);
      step(1, 0, 1, 1, 0, 0);
      check("mdu1_nostall", 64'(ifa.stall_cycles), 64'd7);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      idle(6);
      check("wd_err_b", 64'(ifb.mdu_err), 64'd1);
      check("wd_ok_a", 64'(ifa.mdu_err), 64'd0);
      step(0, 0, 0, 0, 0, 0);
      check("rst_err_b", 64'(ifb.mdu_err), 64'd0);
      idle(1);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 1);
      check("clr_wins", 64'(ifa.stall_cycles), 64'd0);
      for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0, 0);
      check("sat_b", 64'(ifb.stall_cycles), 64'd7);
      check("nosat_a", 64'(ifa.stall_cycles), 64'd9);
      step(1, 0, 1, 0, 0, 0);
      idle(2);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("rst_wait_pc", 64'(ifa.pc_en), 64'd1);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 79) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 39) == 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
